// File: rtl/fifo_sram_writer.sv
// fifo_sram_writer
//   Drains a show-ahead fifo into an SRAM write port. A start request
//   captures a base address and a word count. Words are then popped
//   whenever the fifo has data and the SRAM grants the port. Each popped
//   word becomes a registered SRAM write one cycle later, at consecutive
//   addresses that wrap modulo 2^ADDR_WIDTH.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high reset
//   start       one-cycle transfer request, sampled only while idle
//   base_addr   first SRAM address of the transfer
//   length      number of words to move (0 .. 2^ADDR_WIDTH)
//   pre_empty   fifo empty flag; data_out is valid while low
//   data_out    fifo head word (show-ahead)
//   r_ready     fifo pop strobe (combinational)
//   sram_gnt    SRAM write-port grant
//   sram_we     registered SRAM write enable
//   sram_addr   registered SRAM write address
//   sram_wdata  registered SRAM write data
//   busy        transfer in progress (RUN or DONE)
//   done        one-cycle completion pulse
//   wr_count    words popped so far in the current transfer
//
// state  | meaning
// S_IDLE | waiting for start; wr_count keeps the last result
// S_RUN  | popping words while fifo has data and the port is granted
// S_DONE | single completion cycle; the final write is on the port now

module fifo_sram_writer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  pre_empty,
  input  logic [WIDTH-1:0]      data_out,
  output logic                  r_ready,
  input  logic                  sram_gnt,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]      sram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_ptr;
  logic [ADDR_WIDTH:0]   remaining;

  // The pop strobe must react in the same cycle as pre_empty/sram_gnt,
  // so it cannot be registered; remaining != 0 keeps it from popping a
  // word beyond the requested length.
  assign r_ready = (state == S_RUN) && !pre_empty && sram_gnt && (remaining != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_ptr   <= '0;
      remaining  <= '0;
      wr_count   <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sram_we <= r_ready;

      if (r_ready) begin
        sram_addr  <= addr_ptr;
        sram_wdata <= data_out;
        addr_ptr   <= addr_ptr + ADDR_ONE;  // wraps naturally at 2^ADDR_WIDTH
        remaining  <= remaining - CNT_ONE;
        wr_count   <= wr_count + CNT_ONE;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_ptr  <= base_addr;
            remaining <= length;
            wr_count  <= '0;
            busy      <= 1'b1;
            if (length == '0) begin
              // Nothing to move: go straight to the completion cycle.
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Leaving on the pop of the last word lines the final
          // registered write up with the done pulse.
          if (r_ready && (remaining == CNT_ONE)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sram_writer.sv
// Bench for fifo_sram_writer: a queue-based fifo feeding the DUT, a
// transfer-level reference model checked every cycle, and directed
// transfers with literal expectations.
module tb_fifo_sram_writer;

  localparam int W  = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          pre_empty;
  logic [W-1:0]  data_out;
  logic          r_ready;
  logic          sram_gnt;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;

  fifo_sram_writer #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .pre_empty(pre_empty), .data_out(data_out),
    .r_ready(r_ready), .sram_gnt(sram_gnt), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .busy(busy),
    .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- upstream fifo model ----------------
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_data_q[$];   // words the SRAM must receive, in order
  bit rand_stall = 1'b0;
  bit rr_seen    = 1'b0;

  always @(negedge clk) rr_seen = r_ready && !reset;

  always begin
    bit stall_e;
    @(posedge clk);
    if (rr_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #2;
    stall_e   = rand_stall && ($urandom_range(0, 2) == 0);
    sram_gnt  = !rand_stall || ($urandom_range(0, 3) != 0);
    pre_empty = (fifo_q.size() == 0) || stall_e;
    data_out  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // ---------------- transfer-level reference model ----------------
  typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;
  phase_t        m_phase = P_IDLE;
  logic [AW-1:0] m_base  = '0;
  int            m_rem   = 0;
  int            m_count = 0;
  int            m_wr_idx = 0;
  bit            m_we    = 1'b0;
  bit            e_rr;

  int            done_cnt, we_cnt, rr_cnt, busy_cnt, done_with_we;
  logic [AW-1:0] wlog_addr[$];
  logic [W-1:0]  wlog_data[$];

  always @(negedge clk) begin
    if (reset) begin
      m_phase  = P_IDLE;
      m_we     = 1'b0;
      m_rem    = 0;
      m_count  = 0;
      m_wr_idx = 0;
    end else begin
      e_rr = (m_phase == P_RUN) && (m_rem != 0) && !pre_empty && sram_gnt;
      chk("r_ready", r_ready, e_rr);
      chk("busy", busy, m_phase != P_IDLE);
      chk("done", done, m_phase == P_DONE);
      chk("sram_we", sram_we, m_we);
      chk("wr_count", wr_count, (AW+1)'(m_count));
      if (sram_we) begin
        chk("sram_addr", sram_addr, AW'(m_base + AW'(m_wr_idx)));
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: got write of %0h expected no write", sram_wdata);
        end else begin
          chk("sram_wdata", sram_wdata, exp_data_q[0]);
          void'(exp_data_q.pop_front());
        end
        m_wr_idx++;
        wlog_addr.push_back(sram_addr);
        wlog_data.push_back(sram_wdata);
      end
      if (r_ready) rr_cnt++;
      if (sram_we) we_cnt++;
      if (done) done_cnt++;
      if (done && sram_we) done_with_we++;
      if (busy) busy_cnt++;

      m_we = e_rr;
      case (m_phase)
        P_IDLE: if (start) begin
          m_base   = base_addr;
          m_rem    = int'(length);
          m_count  = 0;
          m_wr_idx = 0;
          m_phase  = (length == '0) ? P_DONE : P_RUN;
        end
        P_RUN: if (e_rr) begin
          m_rem--;
          m_count++;
          if (m_rem == 0) m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_stats();
    done_cnt = 0; we_cnt = 0; rr_cnt = 0; busy_cnt = 0; done_with_we = 0;
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_data_q.push_back(w);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int len);
    start     = 1'b1;
    base_addr = b;
    length    = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_xfer(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("xfer_completed", done_cnt != 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r_ready"}, r_ready, 0);
    chk({tag, "_sram_we"}, sram_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_sram_wdata"}, sram_wdata, 0);
    chk({tag, "_wr_count"}, wr_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    pre_empty = 1'b1; sram_gnt = 1'b1; data_out = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;

    // Directed: eight words 0..7 to 0x010, no stalls.
    clear_stats();
    for (int i = 0; i < 8; i++) push_word(W'(i));
    do_start(10'h010, 8);
    wait_xfer(50);
    chk("t1_rr_cycles", rr_cnt, 8);
    chk("t1_writes", we_cnt, 8);
    chk("t1_busy_cycles", busy_cnt, 9);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_done_with_last_we", done_with_we, 1);
    chk("t1_wr_count", wr_count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", wlog_addr[i], 64'h10 + 64'(i));
      chk("t1_data", wlog_data[i], 64'(i));
    end

    // Directed: address wrap at the top of the SRAM.
    clear_stats();
    push_word(32'hA); push_word(32'hB); push_word(32'hC); push_word(32'hD);
    do_start(10'h3FE, 4);
    wait_xfer(50);
    chk("t2_addr0", wlog_addr[0], 10'h3FE);
    chk("t2_addr1", wlog_addr[1], 10'h3FF);
    chk("t2_addr2", wlog_addr[2], 10'h000);
    chk("t2_addr3", wlog_addr[3], 10'h001);
    chk("t2_data3", wlog_data[3], 32'hD);

    // Zero-length transfer.
    clear_stats();
    do_start(10'h123, 0);
    wait_xfer(10);
    chk("t3_rr_cycles", rr_cnt, 0);
    chk("t3_writes", we_cnt, 0);
    chk("t3_busy_cycles", busy_cnt, 1);
    chk("t3_done_pulses", done_cnt, 1);
    chk("t3_wr_count", wr_count, 0);

    // start pulsed during RUN must be ignored.
    clear_stats();
    for (int i = 0; i < 6; i++) push_word(32'h500 + W'(i));
    do_start(10'h100, 6);
    @(posedge clk); #1;
    do_start(10'h200, 3);
    wait_xfer(50);
    repeat (3) begin @(posedge clk); #1; end
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_busy_after", busy, 0);
    chk("t4_writes", we_cnt, 6);
    chk("t4_last_addr", wlog_addr[5], 10'h105);
    chk("t4_wr_count", wr_count, 6);

    // Random upstream/grant stalls over a 100-word transfer.
    clear_stats();
    rand_stall = 1'b1;
    for (int i = 0; i < 100; i++) push_word($urandom);
    do_start(AW'($urandom_range(0, 1023)), 100);
    wait_xfer(3000);
    rand_stall = 1'b0;
    chk("t5_writes", we_cnt, 100);
    chk("t5_done_pulses", done_cnt, 1);
    chk("t5_wr_count", wr_count, 100);
    chk("t5_fifo_drained", fifo_q.size(), 0);

    // Reset after three of eight words, then resume the remaining five.
    clear_stats();
    for (int i = 0; i < 8; i++) push_word(32'h80 + W'(i));
    do_start(10'h040, 8);
    n = 0;
    while (wr_count != 3 && n < 50) begin @(posedge clk); #1; n++; end
    chk("t6_reached_three", wr_count, 3);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    chk("t6_fifo_left", fifo_q.size(), 5);
    exp_data_q = fifo_q;
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    clear_stats();
    do_start(10'h050, 5);
    wait_xfer(50);
    chk("t6_writes", we_cnt, 5);
    chk("t6_first_data", wlog_data[0], 32'h83);
    chk("t6_last_data", wlog_data[4], 32'h87);
    chk("t6_last_addr", wlog_addr[4], 10'h054);
    chk("t6_wr_count", wr_count, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
